// File: rtl/ibex_pkg.sv
// Shared types for the instruction prefetch path.
package ibex_pkg;

    // One buffered instruction word with its fetch address and bus error flag.
    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } fetch_entry_t;

    // Request FSM: IDLE may issue a new request; REQ_HELD waits for the grant.
    typedef enum logic {
        IDLE     = 1'b0,
        REQ_HELD = 1'b1
    } pf_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ibex_prefetch_fifo.sv
// Circular word FIFO for fetched instructions. Clear wins over push and pop.
module ibex_prefetch_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  fetch_entry_t    entry_in,
    output fetch_entry_t    entry_out,
    output logic [CntW-1:0] count
);

    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;

    fetch_entry_t    mem [Depth];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CntW-1:0] cnt;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
    endfunction

    // Qualify push/pop: a full FIFO may still push if the head pops this cycle.
    always_comb begin
        do_pop  = pop && !clear && (cnt != '0);
        do_push = push && !clear && ((cnt != CntW'(Depth)) || do_pop);
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= entry_in;
    end

    assign entry_out = (cnt != '0) ? mem[rd_ptr] : '0;
    assign count     = cnt;

endmodule

// File: rtl/ibex_prefetch_buffer_nq.sv
// Instruction prefetch buffer: counter-tracked outstanding/discarded requests
// feeding a word FIFO. Discarded in-flight words never reserve FIFO space.
module ibex_prefetch_buffer_nq
    import ibex_pkg::*;
#(
    parameter int unsigned NumReqs   = 2,
    parameter int unsigned FifoDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        branch_mispredict_i,
    input  logic [31:0] mispredict_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        instr_rvalid_i,
    output logic        busy_o
);

    localparam int unsigned OW = $clog2(NumReqs + 1);
    localparam int unsigned FW = $clog2(FifoDepth + 1);

    pf_state_e     state_q, state_d;
    logic [31:0]   fetch_addr_q, held_addr_q, push_addr_q, target;
    logic          held_disc_q;
    logic [OW-1:0] out_cnt_q, disc_cnt_q, out_after;
    logic [FW-1:0] fifo_cnt;
    logic          redirect, room, issue, gnt, held_gnt, resp_drop, push, pop;
    fetch_entry_t  head, push_entry;

    // Redirect decode, response-adjusted outstanding count and FIFO room.
    always_comb begin
        redirect  = branch_i | branch_mispredict_i;
        target    = word_align(branch_i ? addr_i : mispredict_addr_i);
        out_after = (instr_rvalid_i && (out_cnt_q != '0)) ? out_cnt_q - OW'(1) : out_cnt_q;
        room      = (32'(fifo_cnt) + 32'(out_cnt_q) - 32'(disc_cnt_q)) < FifoDepth;
        resp_drop = instr_rvalid_i && (disc_cnt_q != '0);
        push      = instr_rvalid_i && !resp_drop;
    end

    // Request FSM: issue decision, bus request/address, next state.
    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        instr_req_o  = 1'b0;
        instr_addr_o = word_align(fetch_addr_q);
        case (state_q)
            IDLE: begin
                issue        = req_i && (32'(out_after) < NumReqs) && (room || redirect);
                instr_req_o  = issue;
                instr_addr_o = redirect ? target : word_align(fetch_addr_q);
                if (issue && !instr_gnt_i) state_d = REQ_HELD;
            end
            REQ_HELD: begin
                instr_req_o  = 1'b1;
                instr_addr_o = held_addr_q;
                if (instr_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            issue        = 1'b0;
            instr_req_o  = 1'b0;
            instr_addr_o = '0;
        end
    end

    assign gnt      = instr_req_o && instr_gnt_i;
    assign held_gnt = gnt && (state_q == REQ_HELD);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Counters and address registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt_q    <= '0;
            disc_cnt_q   <= '0;
            fetch_addr_q <= '0;
            held_addr_q  <= '0;
            held_disc_q  <= 1'b0;
            push_addr_q  <= '0;
        end else begin
            out_cnt_q <= out_after + OW'(gnt);
            // Everything still in flight at a redirect belongs to the old stream,
            // including a held request that happens to be granted right now.
            if (redirect) disc_cnt_q <= out_after + OW'(held_gnt);
            else          disc_cnt_q <= disc_cnt_q - OW'(resp_drop) + OW'(held_gnt && held_disc_q);
            if (redirect)   fetch_addr_q <= target + (issue ? 32'd4 : 32'd0);
            else if (issue) fetch_addr_q <= fetch_addr_q + 32'd4;
            if (issue) begin
                held_addr_q <= instr_addr_o;
                held_disc_q <= 1'b0;
            end else if (redirect && (state_q == REQ_HELD) && !instr_gnt_i) begin
                held_disc_q <= 1'b1;
            end
            if (redirect)  push_addr_q <= target;
            else if (push) push_addr_q <= push_addr_q + 32'd4;
        end
    end

    // Incoming response word tagged with its expected address.
    always_comb begin
        push_entry       = '0;
        push_entry.rdata = instr_rdata_i;
        push_entry.addr  = push_addr_q;
        push_entry.err   = instr_err_i;
    end

    assign valid_o = (fifo_cnt != '0) && !branch_mispredict_i;
    assign pop     = ready_i && valid_o;

    ibex_prefetch_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (redirect),
        .push      (push),
        .pop       (pop),
        .entry_in  (push_entry),
        .entry_out (head),
        .count     (fifo_cnt)
    );

    assign rdata_o = head.rdata;
    assign addr_o  = head.addr;
    assign err_o   = head.err;
    assign busy_o  = instr_req_o || (out_cnt_q != '0);

endmodule

// File: tb/tb_ibex_prefetch_buffer_nq.sv
// Bench for ibex_prefetch_buffer_nq: queue-based model plus directed scenarios.
module tb_ibex_prefetch_buffer_nq;
    import ibex_pkg::*;

    localparam int NR = 4;
    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        rst_i, req_i, branch_i, branch_mispredict_i, ready_i;
    logic [31:0] addr_i, mispredict_addr_i;
    logic        valid_o, err_o, instr_req_o, instr_gnt_i, instr_err_i, instr_rvalid_i, busy_o;
    logic [31:0] rdata_o, addr_o, instr_addr_o, instr_rdata_i;

    always #5 clk = ~clk;

    ibex_prefetch_buffer_nq #(.NumReqs(NR), .FifoDepth(FD)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
        .branch_mispredict_i(branch_mispredict_i), .mispredict_addr_i(mispredict_addr_i),
        .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
        .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
        .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .instr_rvalid_i(instr_rvalid_i),
        .busy_o(busy_o)
    );

    int total = 0;
    int passed = 0;

    // Model: each in-flight request carries its own address and a drop flag.
    typedef struct {
        logic [31:0] addr;
        bit          disc;
    } out_t;

    out_t         outq[$];
    fetch_entry_t fifo_m[$];
    bit           held, held_disc;
    logic [31:0]  held_addr, fetch_m;
    logic [31:0]  bus_q[$];
    logic [31:0]  gnt_log[$];
    logic [31:0]  err_addr = 32'h1;
    bit           e_issue, e_req, e_valid;
    logic [31:0]  e_addr;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    endtask

    task automatic model_reset();
        outq.delete(); fifo_m.delete(); bus_q.delete();
        held = 0; held_disc = 0; held_addr = '0; fetch_m = '0;
    endtask

    task automatic do_reset();
        rst_i = 1; req_i = 1; branch_i = 1; addr_i = 32'h100; branch_mispredict_i = 0;
        mispredict_addr_i = '0; ready_i = 0; instr_gnt_i = 1; instr_rvalid_i = 0;
        instr_rdata_i = '0; instr_err_i = 0;
        @(posedge clk); #1;
        chk("rst_instr_req", 32'(instr_req_o), 0);
        chk("rst_instr_addr", instr_addr_o, 0);
        @(posedge clk); #1;
        rst_i = 0; req_i = 0; branch_i = 0; instr_gnt_i = 0;
        model_reset();
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_req", 32'(instr_req_o), 0);
    endtask

    // Drive one cycle of inputs, then check DUT outputs against the model.
    task automatic drive(input bit rq, input bit br, input logic [31:0] ba, input bit mp,
                         input logic [31:0] ma, input bit rdy, input bit g, input bit rv,
                         input bit rerr);
        int  live, outa;
        bit  redir;
        req_i = rq; branch_i = br; addr_i = ba; branch_mispredict_i = mp;
        mispredict_addr_i = ma; ready_i = rdy; instr_gnt_i = g;
        instr_rvalid_i = rv && (bus_q.size() > 0);
        instr_rdata_i  = $urandom;
        instr_err_i    = instr_rvalid_i && ((bus_q[0] == err_addr) || rerr);
        #1;
        redir = br || mp;
        live = 0;
        foreach (outq[i]) if (!outq[i].disc) live++;
        outa = outq.size() - (instr_rvalid_i ? 1 : 0);
        e_issue = !held && rq && (outa < NR) && (redir || (fifo_m.size() + live < FD));
        e_req   = held || e_issue;
        e_addr  = held ? held_addr : br ? ba : mp ? ma : fetch_m;
        e_addr[1:0] = 2'b00;
        e_valid = (fifo_m.size() > 0) && !mp;
        chk("instr_req", 32'(instr_req_o), 32'(e_req));
        if (e_req) chk("instr_addr", instr_addr_o, e_addr);
        chk("valid", 32'(valid_o), 32'(e_valid));
        chk("busy", 32'(busy_o), 32'(e_req || (outq.size() > 0)));
        if (fifo_m.size() > 0) begin
            chk("rdata", rdata_o, fifo_m[0].rdata);
            chk("addr", addr_o, fifo_m[0].addr);
            chk("err", 32'(err_o), 32'(fifo_m[0].err));
        end
    endtask

    // Advance the model by the driven cycle and step the clock.
    task automatic adv();
        bit           redir, g;
        logic [31:0]  tgt;
        out_t         o, n;
        fetch_entry_t fe;
        redir = branch_i || branch_mispredict_i;
        g     = e_req && instr_gnt_i;
        tgt   = branch_i ? addr_i : mispredict_addr_i;
        tgt[1:0] = 2'b00;
        if (e_valid && ready_i && !redir) void'(fifo_m.pop_front());
        if (instr_rvalid_i) begin
            o = outq.pop_front();
            void'(bus_q.pop_front());
            if (!o.disc && !redir) begin
                fe.rdata = instr_rdata_i; fe.addr = o.addr; fe.err = instr_err_i;
                fifo_m.push_back(fe);
            end
        end
        if (redir) begin
            fifo_m.delete();
            foreach (outq[i]) outq[i].disc = 1;
        end
        if (held) begin
            if (instr_gnt_i) begin
                n.addr = held_addr; n.disc = held_disc || redir;
                outq.push_back(n);
                held = 0;
            end else if (redir) held_disc = 1;
        end else if (e_issue) begin
            if (instr_gnt_i) begin
                n.addr = e_addr; n.disc = 0;
                outq.push_back(n);
            end else begin
                held = 1; held_addr = e_addr; held_disc = 0;
            end
        end
        if (redir)        fetch_m = tgt + (e_issue ? 32'd4 : 32'd0);
        else if (e_issue) fetch_m = fetch_m + 32'd4;
        if (g) begin
            bus_q.push_back(e_addr);
            gnt_log.push_back(e_addr);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Sequential fetch from 0x100, error on the 0x104 response.
        do_reset();
        err_addr = 32'h104; gnt_log.delete();
        drive(1, 1, 32'h100, 0, 0, 1, 1, 0, 0); chk("A_addr0", instr_addr_o, 32'h100); adv();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);       chk("A_addr1", instr_addr_o, 32'h104); adv();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("A_valid", 32'(valid_o), 1); chk("A_head", addr_o, 32'h100); chk("A_err0", 32'(err_o), 0); adv();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("E_head", addr_o, 32'h104); chk("E_err", 32'(err_o), 1); adv();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0); adv();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("E_next_head", addr_o, 32'h108); chk("E_next_err", 32'(err_o), 0); adv();
        chk("A_gnt0", gnt_log[0], 32'h100);
        chk("A_gnt1", gnt_log[1], 32'h104);
        chk("A_gnt2", gnt_log[2], 32'h108);
        err_addr = 32'h1;

        // No responses: FIFO room limits the in-flight count to 2.
        do_reset(); gnt_log.delete();
        drive(1, 1, 32'h400, 0, 0, 0, 1, 0, 0); adv();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 0, 0); adv();
        end
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("B_req_stalled", 32'(instr_req_o), 0);
        chk("B_gnt_count", 32'(gnt_log.size()), 2);

        // Branch to 0x200 with 2 outstanding: both old words dropped.
        branch_i = 0;
        drive(1, 1, 32'h200, 0, 0, 0, 1, 0, 0);
        chk("C_req", 32'(instr_req_o), 1); chk("C_addr", instr_addr_o, 32'h200); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); chk("C_dropped", 32'(valid_o), 0); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("C_valid", 32'(valid_o), 1); chk("C_head", addr_o, 32'h200); adv();

        // Held request survives a branch, then its response is dropped.
        do_reset();
        drive(1, 1, 32'h500, 0, 0, 0, 0, 0, 0); adv();
        drive(1, 1, 32'h300, 0, 0, 0, 0, 0, 0); chk("D_hold0", instr_addr_o, 32'h500); adv();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);       chk("D_hold1", instr_addr_o, 32'h500); adv();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);       chk("D_target", instr_addr_o, 32'h300); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("D_valid", 32'(valid_o), 1); chk("D_head", addr_o, 32'h300); adv();

        // Address wrap with the FIFO one short of full.
        do_reset();
        drive(1, 1, 32'hFFFF_FFF8, 0, 0, 0, 1, 0, 0); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); adv();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0); chk("F_top", instr_addr_o, 32'hFFFF_FFFC); adv();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0); chk("F_stall0", 32'(instr_req_o), 0); adv();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0); chk("F_stall1", 32'(instr_req_o), 0); adv();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0); chk("F_stall2", 32'(instr_req_o), 0); adv();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("F_wrap_req", 32'(instr_req_o), 1); chk("F_wrap_addr", instr_addr_o, 32'h0); adv();

        // Randomized traffic with periodic resets.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            drive(1, 1, $urandom, 0, 0, 0, 1, 0, 0); adv();
            for (int k = 0; k < 800; k++) begin
                drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 5, $urandom,
                      $urandom_range(0, 99) < 3, $urandom, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 99) < (blk == 2 ? 90 : 60),
                      $urandom_range(0, 99) < (blk == 3 ? 30 : 60),
                      $urandom_range(0, 99) < 10);
                adv();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
